// File: rtl/systolic_pkg.sv
// Shared types and semiring arithmetic for the systolic FIR engine.
// Values are carried zero-extended in a wide container and trimmed by callers.
package systolic_pkg;

    typedef enum logic [1:0] {
        MODE_MOD  = 2'b00,
        MODE_SAT  = 2'b01,
        MODE_TROP = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN
    } state_e;

    localparam int SR_MAXW = 32;

    typedef logic [2*SR_MAXW-1:0] sr_t;

    function automatic sr_t sr_ones(int w);
        sr_t r;
        r = (sr_t'(1) << w) - sr_t'(1);
        return r;
    endfunction

    function automatic sr_t sr_clamp(sr_t v, int w);
        sr_t m;
        m = sr_ones(w);
        return (v > m) ? m : v;
    endfunction

    // TROP treats all-ones as +inf, so a clamped add absorbs it.
    function automatic sr_t sr_mul(mode_e mode, sr_t a, sr_t b, int w);
        sr_t r;
        unique case (mode)
            MODE_SAT:  r = sr_clamp(a * b, w);
            MODE_TROP: r = sr_clamp(a + b, w);
            default:   r = (a * b) & sr_ones(w);
        endcase
        return r;
    endfunction

    function automatic sr_t sr_add(mode_e mode, sr_t a, sr_t b, int w);
        sr_t r;
        unique case (mode)
            MODE_SAT:  r = sr_clamp(a + b, w);
            MODE_TROP: r = (a < b) ? a : b;
            default:   r = (a + b) & sr_ones(w);
        endcase
        return r;
    endfunction

    function automatic sr_t sr_zero(mode_e mode, int w);
        sr_t r;
        r = (mode == MODE_TROP) ? sr_ones(w) : sr_t'(0);
        return r;
    endfunction

endpackage

// File: rtl/semiring_cell.sv
// One systolic tap: stationary weight, two-deep x delay, partial sum and
// its valid bit. The first cell taps x directly and has no delay pair.
module semiring_cell
    import systolic_pkg::*;
#(
    parameter int W     = 8,
    parameter bit FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  mode_e        mode,
    input  logic         adv,
    input  logic         w_we,
    input  logic [W-1:0] w_data,
    input  logic [W-1:0] x_in,
    output logic [W-1:0] x_tap,
    input  logic [W-1:0] p_in,
    input  logic         v_in,
    input  logic         v_clr,
    output logic [W-1:0] p_out,
    output logic         v_out
);

    logic [W-1:0] w_q;
    logic [W-1:0] p_q;
    logic         v_q;
    logic [W-1:0] prod;
    logic [W-1:0] sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '0;
        end else if (w_we) begin
            w_q <= w_data;
        end
    end

    generate
        if (FIRST) begin : g_direct
            assign x_tap = x_in;
        end else begin : g_delay
            logic [W-1:0] d1_q;
            logic [W-1:0] d2_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    d1_q <= '0;
                    d2_q <= '0;
                end else if (adv) begin
                    d1_q <= x_in;
                    d2_q <= d1_q;
                end
            end

            assign x_tap = d2_q;
        end
    endgenerate

    always_comb begin
        prod = W'(sr_mul(mode, sr_t'(w_q), sr_t'(x_tap), W));
        sum  = prod;
        if (!FIRST) begin
            sum = W'(sr_add(mode, sr_t'(p_in), sr_t'(prod), W));
        end
    end

    // A consumed output may retire without an advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
            v_q <= 1'b0;
        end else if (adv) begin
            p_q <= sum;
            v_q <= v_in;
        end else if (v_clr) begin
            v_q <= 1'b0;
        end
    end

    assign p_out = p_q;
    assign v_out = v_q;

endmodule

// File: rtl/systolic_semiring_fir.sv
// Systolic semiring FIR: N stationary-weight cells with weight load,
// run and drain phases and valid/ready streaming on both sides.
module systolic_semiring_fir
    import systolic_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   mode,
    input  logic         w_valid,
    input  logic [W-1:0] w_data,
    input  logic         start,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         busy
);

    localparam int CW = $clog2(N);

    state_e        state_q;
    state_e        state_d;
    mode_e         mode_q;
    logic [CW-1:0] lcnt_q;
    logic [CW-1:0] dcnt_q;

    logic          adv;
    logic          out_v;
    logic          w_ok;
    logic [W-1:0]  x_src;
    logic          v_src;

    logic [W-1:0]  x_link [N+1];
    logic [W-1:0]  p_link [N+1];
    logic          v_link [N+1];

    assign in_ready = (state_q == ST_RUN) && (!out_v || out_ready);
    assign adv = ((state_q == ST_RUN) && in_valid && in_ready)
              || ((state_q == ST_DRAIN) && (!out_v || out_ready));
    assign busy = (state_q != ST_IDLE);
    assign w_ok = w_valid && ((state_q == ST_IDLE) || (state_q == ST_LOAD));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (w_valid) begin
                    state_d = ST_LOAD;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (w_valid && lcnt_q == CW'(N - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (adv && dcnt_q == CW'(N - 2)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_MOD;
            lcnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && state_d == ST_RUN) begin
                mode_q <= mode_e'(mode);
            end
            if (w_ok) begin
                lcnt_q <= (lcnt_q == CW'(N - 1)) ? '0 : lcnt_q + CW'(1);
            end
            if (state_q == ST_DRAIN && adv) begin
                dcnt_q <= (dcnt_q == CW'(N - 2)) ? '0 : dcnt_q + CW'(1);
            end
        end
    end

    // Drain bubbles carry the annihilator so stale taps contribute nothing.
    assign x_src = (state_q == ST_DRAIN) ? W'(sr_zero(mode_q, W)) : in_data;
    assign v_src = (state_q == ST_RUN);

    assign x_link[0] = x_src;
    assign p_link[0] = '0;
    assign v_link[0] = v_src;

    generate
        for (genvar k = 0; k < N; k++) begin : g_cell
            semiring_cell #(
                .W     (W),
                .FIRST (k == 0)
            ) u_cell (
                .clk    (clk),
                .rst    (rst),
                .mode   (mode_q),
                .adv    (adv),
                .w_we   (w_ok && lcnt_q == CW'(k)),
                .w_data (w_data),
                .x_in   (x_link[k]),
                .x_tap  (x_link[k+1]),
                .p_in   (p_link[k]),
                .v_in   (v_link[k]),
                .v_clr  ((k == N - 1) ? (out_v && out_ready && !adv) : 1'b0),
                .p_out  (p_link[k+1]),
                .v_out  (v_link[k+1])
            );
        end
    endgenerate

    assign out_v     = v_link[N];
    assign out_valid = out_v;
    assign out_data  = p_link[N];

endmodule

// File: tb/tb_systolic_semiring_fir.sv
// Randomized bench for systolic_semiring_fir against a tap-history
// model of y[t] = sum_k w_k * x[t-k] in the selected semiring.
module tb_systolic_semiring_fir;

    localparam int W = 8;
    localparam int N = 4;
    localparam int unsigned MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   mode = 2'd0;
    logic         w_valid = 1'b0;
    logic [W-1:0] w_data = '0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b1;
    logic         busy;

    int errs = 0;
    int checks = 0;

    int unsigned wts [N];
    int unsigned wl [N];
    int unsigned hist [$];
    int unsigned expq [$];
    int unsigned xs [$];
    int n_out = 0;
    int exp_n = 0;
    logic [1:0] cur_mode = 2'd0;
    bit in_run = 1'b0;

    int cyc = 0;
    int stall_lo = -1;
    int stall_hi = -1;
    bit rnd_ready = 1'b0;

    logic [W-1:0] hold_d = '0;
    bit hold_pend = 1'b0;

    systolic_semiring_fir #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .w_valid   (w_valid),
        .w_data    (w_data),
        .start     (start),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog errors=%0d", errs);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned m_mul(logic [1:0] md, int unsigned a,
                                          int unsigned b);
        int unsigned r;
        if (md == 2'd1)      r = (a * b > MAXV) ? MAXV : a * b;
        else if (md == 2'd2) r = (a + b > MAXV) ? MAXV : a + b;
        else                 r = (a * b) % (MAXV + 1);
        return r;
    endfunction

    function automatic int unsigned m_add(logic [1:0] md, int unsigned a,
                                          int unsigned b);
        int unsigned r;
        if (md == 2'd1)      r = (a + b > MAXV) ? MAXV : a + b;
        else if (md == 2'd2) r = (a < b) ? a : b;
        else                 r = (a + b) % (MAXV + 1);
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        expq.delete();
        for (int k = 0; k < N - 1; k++) hist.push_back(0);
        for (int k = 0; k < N; k++) wts[k] = 0;
    endtask

    task automatic model_accept(input int unsigned x);
        int unsigned acc;
        hist.push_back(x);
        acc = m_mul(cur_mode, wts[0], x);
        for (int k = 1; k < N; k++) begin
            acc = m_add(cur_mode, acc,
                        m_mul(cur_mode, wts[k], hist[hist.size() - 1 - k]));
        end
        expq.push_back(acc);
        exp_n++;
    endtask

    task automatic model_drain();
        for (int k = 0; k < N - 1; k++) begin
            hist.push_back((cur_mode == 2'd2) ? MAXV : 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            out_ready = !(cyc >= stall_lo && cyc < stall_hi)
                     && (!rnd_ready || $urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_v", 32'(out_valid), 32'd1);
                chk("hold_d", 32'(out_data), 32'(hold_d));
            end
            if (in_run && out_valid && !out_ready) begin
                chk("stall_rdy", 32'(in_ready), 32'd0);
            end
            hold_pend = out_valid && !out_ready;
            hold_d = out_data;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) chk("extra_out", 32'(n_out + 1), 32'(exp_n));
                else chk("y", 32'(out_data), expq.pop_front());
                n_out++;
            end
        end
    end

    task automatic load_w(input bit st_first, input bit st_last, input bit gaps);
        for (int k = 0; k < N; k++) begin
            if (gaps && k > 0 && $urandom_range(0, 1) == 1) begin
                w_valid = 1'b0;
                step();
                step();
            end
            w_valid = 1'b1;
            w_data = W'(wl[k]);
            start = (k == 0 && st_first) || (k == N - 1 && st_last);
            step();
            wts[k] = wl[k];
            if (k == 0) chk("load_busy", 32'(busy), 32'd1);
        end
        w_valid = 1'b0;
        start = 1'b0;
        chk("load_idle", 32'(busy), 32'd0);
    endtask

    task automatic do_run(input logic [1:0] md, input bit same_flush,
                          input bit gaps);
        int t;
        bit got;
        mode = md;
        start = 1'b1;
        step();
        start = 1'b0;
        mode = 2'($urandom);
        cur_mode = md;
        n_out = 0;
        exp_n = 0;
        in_run = 1'b1;
        chk("run_busy", 32'(busy), 32'd1);
        foreach (xs[i]) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_data = W'(xs[i]);
            got = 1'b0;
            t = 0;
            while (!got && t < 100) begin
                @(negedge clk);
                if (in_ready) begin
                    got = 1'b1;
                    model_accept(xs[i]);
                    if (same_flush && i == xs.size() - 1) flush = 1'b1;
                end
                @(posedge clk);
                #1;
                t++;
            end
            flush = 1'b0;
            if (!got) chk("accept_to", 32'(t), 32'd0);
        end
        in_valid = 1'b0;
        if (!same_flush) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
        end
        model_drain();
        t = 0;
        while ((busy || expq.size() != 0) && t < 300) begin
            step();
            t++;
        end
        chk("drain_idle", 32'(busy), 32'd0);
        chk("n_out", 32'(n_out), 32'(xs.size()));
        in_run = 1'b0;
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        step();
        step();
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_od", 32'(out_data), 32'd0);
        chk("rst_ir", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_busy", 32'(busy), 32'd0);

        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_idle", 32'(busy), 32'd0);

        // impulse with exact latency and drain length
        wl = '{1, 2, 3, 4};
        load_w(1'b1, 1'b0, 1'b0);
        mode = 2'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        cur_mode = 2'd0;
        n_out = 0;
        exp_n = 0;
        in_run = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data = (i == 0) ? W'(1) : W'(0);
            flush = (i == N - 1);
            model_accept(int'(in_data));
            step();
            if (i < N - 1) chk("imp_lat", 32'(out_valid), 32'd0);
        end
        chk("imp_first_v", 32'(out_valid), 32'd1);
        chk("imp_first_d", 32'(out_data), 32'd1);
        in_valid = 1'b0;
        flush = 1'b0;
        model_drain();
        step();
        chk("drain1", 32'(busy), 32'd1);
        step();
        chk("drain2", 32'(busy), 32'd1);
        step();
        chk("drain_end", 32'(busy), 32'd0);
        step();
        chk("imp_n_out", 32'(n_out), 32'd4);
        chk("idle_clr", 32'(out_valid), 32'd0);
        in_run = 1'b0;

        // wrap, saturation, reserved mode
        wl = '{16, 16, 1, 1};
        load_w(1'b0, 1'b1, 1'b0);
        xs = '{20, 20};
        do_run(2'd0, 1'b0, 1'b0);
        do_run(2'd1, 1'b0, 1'b0);
        xs = '{200, 20, 255, 3, 17};
        do_run(2'd3, 1'b1, 1'b0);

        // tropical, second pass starts from an all-inf history
        wl = '{0, 3, 255, 1};
        load_w(1'b0, 1'b0, 1'b1);
        xs = '{5, 2, 7, 9};
        do_run(2'd2, 1'b1, 1'b0);
        do_run(2'd2, 1'b1, 1'b0);

        // backpressure window mid-stream
        xs.delete();
        for (int i = 0; i < 12; i++) xs.push_back($urandom_range(0, MAXV));
        stall_lo = cyc + 5;
        stall_hi = stall_lo + 5;
        do_run(2'd0, 1'b0, 1'b0);

        // randomized weights, modes, gaps and ready
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < N; k++) begin
                wl[k] = ($urandom_range(0, 3) == 0) ? MAXV : $urandom_range(0, MAXV);
            end
            load_w(1'b0, it == 0, 1'b1);
            xs.delete();
            for (int i = 0; i < int'($urandom_range(3, 10)); i++) begin
                xs.push_back(($urandom_range(0, 4) == 0) ? MAXV : $urandom_range(0, MAXV));
            end
            rnd_ready = 1'b1;
            do_run(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
            rnd_ready = 1'b0;
        end

        // reset in the middle of a run
        for (int k = 0; k < N; k++) wl[k] = $urandom_range(1, MAXV);
        load_w(1'b0, 1'b0, 1'b0);
        mode = 2'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        in_run = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data = W'($urandom_range(1, MAXV));
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_ov", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_od", 32'(out_data), 32'd0);
        in_run = 1'b0;
        model_reset();
        step();
        rst = 1'b0;
        step();
        xs.delete();
        for (int i = 0; i < 6; i++) xs.push_back($urandom_range(1, MAXV));
        do_run(2'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
